// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Imported by the top, the magnitude helper and the testbench.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MULT_SIGNED   = 1'b1;
   localparam logic MULT_UNSIGNED = 1'b0;

   // Width of the RUN-cycle counter; cnt only ever reaches WIDTH-1.
   function automatic int clog2(input int value);
      return $clog2(value);
   endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/product bus of seq_multiplier: request channel in, product channel out.
interface seq_multiplier_if #(
   parameter int WIDTH = 8
);

   // Both channels use strict valid/ready: a transfer happens on the rising
   // edge where valid && ready; the sender holds its payload stable until then,
   // and valid never waits on ready (ready may depend on valid, not vice versa).
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 signed_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;

   modport master (
      output in_valid,
      output a,
      output b,
      output signed_mode,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  p,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  signed_mode,
      input  out_ready,
      output in_ready,
      output out_valid,
      output p,
      output busy
   );

endinterface

// File: rtl/mult_abs.sv
// Operand magnitude for the multiplier: WIDTH+1 bits so that -2^(WIDTH-1)
// maps to +2^(WIDTH-1) without wrapping; o_sign is set only in signed mode.
module mult_abs
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_op,
   input  logic             i_signed_mode,
   output logic [WIDTH:0]   o_mag,
   output logic             o_sign
);

   logic           w_neg;
   logic [WIDTH:0] w_ext;

   assign w_neg  = (i_signed_mode == MULT_SIGNED) && i_op[WIDTH-1];
   // Sign-extend negatives, zero-extend everything else, then negate in WIDTH+1 bits.
   assign w_ext  = {w_neg, i_op};
   assign o_mag  = w_neg ? (~w_ext + 1'b1) : w_ext;
   assign o_sign = w_neg;

endmodule

// File: rtl/seq_multiplier.sv
// WIDTH x WIDTH shift-add multiplier, one partial product per cycle, fixed
// latency of WIDTH cycles; unsigned or two's-complement via sign/magnitude.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_multiplier_if.slave io_mult,
   output state_t          o_state
);

   localparam int CNT_W = clog2(WIDTH);
   localparam int PW    = 2 * WIDTH;

   state_t           r_state;
   logic [WIDTH:0]   r_mcand;
   logic [WIDTH:0]   r_mplier;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_p;
   logic [CNT_W-1:0] r_cnt;
   logic             r_neg;
   logic             r_out_valid;
   logic             r_ready_en;

   state_t           w_state_nxt;
   logic [WIDTH:0]   w_mcand_nxt;
   logic [WIDTH:0]   w_mplier_nxt;
   logic [PW-1:0]    w_acc_nxt;
   logic [PW-1:0]    w_p_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_neg_nxt;
   logic             w_out_valid_nxt;

   logic [WIDTH:0]   w_mag_a;
   logic [WIDTH:0]   w_mag_b;
   logic             w_sign_a;
   logic             w_sign_b;
   logic             w_accept;
   logic             w_last;
   logic [PW-1:0]    w_addend;
   logic [PW-1:0]    w_acc_sum;

   mult_abs #(.WIDTH(WIDTH)) u_abs_a (
      .i_op          (io_mult.a),
      .i_signed_mode (io_mult.signed_mode),
      .o_mag         (w_mag_a),
      .o_sign        (w_sign_a)
   );

   mult_abs #(.WIDTH(WIDTH)) u_abs_b (
      .i_op          (io_mult.b),
      .i_signed_mode (io_mult.signed_mode),
      .o_mag         (w_mag_b),
      .o_sign        (w_sign_b)
   );

   // r_ready_en keeps in_ready low while reset is held and through the reset edge.
   assign io_mult.in_ready  = (r_state == IDLE) && r_ready_en;
   assign io_mult.out_valid = r_out_valid;
   assign io_mult.p         = r_p;
   assign io_mult.busy      = (r_state != IDLE);
   assign o_state           = r_state;

   assign w_accept  = io_mult.in_valid && io_mult.in_ready;
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_addend  = r_mplier[0] ? (PW'(r_mcand) << r_cnt) : '0;
   assign w_acc_sum = r_acc + w_addend;

   always_comb begin
      w_state_nxt     = r_state;
      w_mcand_nxt     = r_mcand;
      w_mplier_nxt    = r_mplier;
      w_acc_nxt       = r_acc;
      w_p_nxt         = r_p;
      w_cnt_nxt       = r_cnt;
      w_neg_nxt       = r_neg;
      w_out_valid_nxt = r_out_valid;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_mcand_nxt  = w_mag_a;
               w_mplier_nxt = w_mag_b;
               w_neg_nxt    = w_sign_a ^ w_sign_b;
               w_acc_nxt    = '0;
               w_cnt_nxt    = '0;
               w_state_nxt  = RUN;
            end
         end
         RUN: begin
            w_acc_nxt    = w_acc_sum;
            w_mplier_nxt = r_mplier >> 1;
            w_cnt_nxt    = r_cnt + 1'b1;
            if (w_last) begin
               w_p_nxt         = r_neg ? (~w_acc_sum + PW'(1)) : w_acc_sum;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = DONE;
            end
         end
         DONE: begin
            if (io_mult.out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = IDLE;
            end
         end
         default: begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_p         <= '0;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         r_out_valid <= 1'b0;
         r_ready_en  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mcand     <= w_mcand_nxt;
         r_mplier    <= w_mplier_nxt;
         r_acc       <= w_acc_nxt;
         r_p         <= w_p_nxt;
         r_cnt       <= w_cnt_nxt;
         r_neg       <= w_neg_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_ready_en  <= 1'b1;
      end
   end

endmodule
